// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding modes, fflags bit positions and float format widths.
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int DP_EXP_W = 11;
  localparam int DP_MAN_W = 52;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  localparam int SP_BIAS = 127;
  localparam int DP_BIAS = 1023;

endpackage

// File: rtl/fcvt_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fcvt_lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]       in_i,
  output logic [$clog2(W):0] cnt_o
);

  localparam int CW = $clog2(W) + 1;

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fcvt_i2f_pipe.sv
// Three-stage integer-to-float converter: magnitude, normalise, round.
// Valid/ready handshake per stage; a tag travels with each op.
module fcvt_i2f_pipe
  import fpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int EXP_W = SP_EXP_W,
  parameter int MAN_W = SP_MAN_W,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_int,
  input  logic                     in_unsign,
  input  logic [2:0]               in_rm,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_fp,
  output logic                     out_nx,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int LZ_W  = $clog2(XLEN) + 1;
  localparam int BIAS  = fp_bias(EXP_W);
  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int EXT_W = XLEN - 1 + MAN_W + 2;

  logic             s1_valid_q, s1_sign_q, s1_zero_q;
  logic [XLEN-1:0]  s1_mag_q;
  logic [2:0]       s1_rm_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_sign_q, s2_zero_q;
  logic [XLEN-2:0]  s2_norm_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [2:0]       s2_rm_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             out_valid_q, out_nx_q;
  logic [FP_W-1:0]  out_fp_q;
  logic [TAG_W-1:0] out_tag_q;

  logic out_free, s2_adv, s2_free, s1_adv;

  assign out_free = ~out_valid_q | out_ready;
  assign s2_adv   = s2_valid_q & out_free;
  assign s2_free  = ~s2_valid_q | s2_adv;
  assign s1_adv   = s1_valid_q & s2_free;
  assign in_ready = ~s1_valid_q | s1_adv;

  // S1: sign/magnitude. Negating -2^(XLEN-1) wraps to itself, which is the right magnitude.
  logic            s1_sign_d;
  logic [XLEN-1:0] s1_mag_d;
  assign s1_sign_d = ~in_unsign & in_int[XLEN-1];
  assign s1_mag_d  = s1_sign_d ? (-in_int) : in_int;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_rm_q    <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_valid & in_ready) begin
        s1_sign_q <= s1_sign_d;
        s1_zero_q <= (s1_mag_d == '0);
        s1_mag_q  <= s1_mag_d;
        s1_rm_q   <= in_rm;
        s1_tag_q  <= in_tag;
      end
    end
  end

  // S2: normalise; the implicit leading one is dropped from the stored fraction.
  logic [LZ_W-1:0]  s1_lz;
  logic [XLEN-2:0]  s2_norm_d;
  logic [EXP_W-1:0] s2_exp_d;

  fcvt_lzc #(.W(XLEN)) u_lzc (
    .in_i  (s1_mag_q),
    .cnt_o (s1_lz)
  );

  assign s2_norm_d = (XLEN-1)'(s1_mag_q << s1_lz);
  assign s2_exp_d  = EXP_W'(BIAS + XLEN - 1 - int'(s1_lz));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_norm_q  <= '0;
      s2_exp_q   <= '0;
      s2_rm_q    <= '0;
      s2_tag_q   <= '0;
    end else begin
      if (s2_free) s2_valid_q <= s1_valid_q;
      if (s1_adv) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s1_zero_q;
        s2_norm_q <= s2_norm_d;
        s2_exp_q  <= s2_exp_d;
        s2_rm_q   <= s1_rm_q;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  // S3: round. Zero padding keeps guard/sticky well-defined when no bits are dropped.
  logic [EXT_W-1:0] ext;
  logic [MAN_W-1:0] mant;
  logic             guard, sticky, inc;
  logic [MAN_W:0]   mant_sum;
  logic [FP_W-1:0]  out_fp_d;
  logic             out_nx_d;

  assign ext    = {s2_norm_q, {(MAN_W+2){1'b0}}};
  assign mant   = ext[EXT_W-1 -: MAN_W];
  assign guard  = ext[EXT_W-1-MAN_W];
  assign sticky = |ext[EXT_W-2-MAN_W:0];

  always_comb begin
    inc = 1'b0;
    case (s2_rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_sign_q & (guard | sticky);
      RM_RUP:  inc = ~s2_sign_q & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mant[0]);
    endcase
  end

  assign mant_sum = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
  assign out_fp_d = s2_zero_q ? '0
                  : {s2_sign_q, s2_exp_q + EXP_W'(mant_sum[MAN_W]), mant_sum[MAN_W-1:0]};
  assign out_nx_d = guard | sticky;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_fp_q    <= '0;
      out_nx_q    <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      if (out_free) out_valid_q <= s2_valid_q;
      if (s2_adv) begin
        out_fp_q  <= out_fp_d;
        out_nx_q  <= out_nx_d;
        out_tag_q <= s2_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_fp    = out_fp_q;
  assign out_nx    = out_nx_q;
  assign out_tag   = out_tag_q;

endmodule
